// File: rtl/mips_fetch_pkg.sv
// Shared types and constants for the MIPS instruction-fetch queue.
package mips_fetch_pkg;

    typedef enum logic [1:0] {
        S_BOOT,
        S_RUN,
        S_DRAIN
    } fetch_state_t;

    localparam int          WORD_BYTES       = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    function automatic logic [31:0] next_word(input logic [31:0] addr);
        return addr + 32'(WORD_BYTES);
    endfunction

endpackage

// File: rtl/mips_fetch_queue_if.sv
// Instruction-memory request/response port between the fetch unit (master) and memory (slave).
interface mips_fetch_queue_if;

    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic [31:0] rsp_data;

    modport master (
        output req_valid,
        output req_addr,
        input  req_ready,
        input  rsp_valid,
        input  rsp_data
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        output req_ready,
        output rsp_valid,
        output rsp_data
    );

endinterface

// File: rtl/mips_fetch_fifo.sv
// First-word-fall-through FIFO holding {instruction, pc+4} pairs; clear wins over push.
module mips_fetch_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 64,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

    // Storage needs no reset: the count gates every read of it.
    always_ff @(posedge clk) begin
        if (push && !clear) mem[wr_ptr] <= din;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/mips_fetch_queue.sv
// Fetch front end: PC, credit-limited imem requests, stale-return dropping and IF/ID queue.
// Optional FETCH_PERF_CNT_EN adds perf_fetched/perf_dropped/perf_stall counters.
module mips_fetch_queue
    import mips_fetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter int          MAX_OUT  = 2,
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               redirect,
    input  logic [31:0]        redirect_pc,
    mips_fetch_queue_if.master imem,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [31:0]        instr_out,
    output logic [31:0]        instr_pc4
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]        perf_fetched,
    output logic [31:0]        perf_dropped,
    output logic [31:0]        perf_stall
`endif
);

    localparam int             CW        = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0]  MAX_OUT_C = CW'(MAX_OUT);
    localparam logic [CW:0]    DEPTH_C   = (CW+1)'(DEPTH);

    fetch_state_t  state;
    fetch_state_t  state_next;
    logic [31:0]   fetch_pc;
    logic [31:0]   fetch_pc_next;
    logic [31:0]   track_pc;
    logic [31:0]   track_pc_next;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] outstanding_next;
    logic [CW-1:0] drop;
    logic [CW-1:0] drop_next;
    logic [CW-1:0] count;
    logic [63:0]   head;
    logic          credit_ok;
    logic          issue;
    logic          accept;
    logic          stale;
    logic          push;
    logic          pop;

    // Queued words plus words in flight never exceed DEPTH, so every return has a slot.
    assign credit_ok = (outstanding < MAX_OUT_C) &&
                       (({1'b0, count} + {1'b0, outstanding}) < DEPTH_C);
    assign issue     = (state == S_RUN) && !redirect && credit_ok;
    assign accept    = issue && imem.req_ready;
    assign stale     = redirect || (drop != '0);
    assign push      = imem.rsp_valid && !stale;
    assign instr_valid = (count != '0);
    assign pop       = instr_valid && instr_ready;

    assign imem.req_valid = issue;
    assign imem.req_addr  = issue ? fetch_pc : '0;
    assign instr_out      = instr_valid ? head[63:32] : '0;
    assign instr_pc4      = instr_valid ? head[31:0]  : '0;

    mips_fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (64)
    ) fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .clear (redirect),
        .din   ({imem.rsp_data, next_word(track_pc)}),
        .head  (head),
        .count (count)
    );

    always_comb begin
        state_next       = state;
        fetch_pc_next    = fetch_pc;
        track_pc_next    = track_pc;
        outstanding_next = outstanding;
        drop_next        = drop;

        if (accept && !imem.rsp_valid)      outstanding_next = outstanding + CW'(1);
        else if (!accept && imem.rsp_valid) outstanding_next = outstanding - CW'(1);

        if (accept) fetch_pc_next = next_word(fetch_pc);
        if (push)   track_pc_next = next_word(track_pc);
        if (imem.rsp_valid && (drop != '0)) drop_next = drop - CW'(1);

        case (state)
            S_BOOT:  state_next = S_RUN;
            S_DRAIN: if (drop == '0) state_next = S_RUN;
            default: ;
        endcase

        // Everything still in flight at a redirect belongs to the old path.
        if (redirect) begin
            fetch_pc_next = redirect_pc;
            track_pc_next = redirect_pc;
            drop_next     = outstanding_next;
            state_next    = (outstanding_next != '0) ? S_DRAIN : S_RUN;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_BOOT;
            fetch_pc    <= RESET_PC;
            track_pc    <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
        end else begin
            state       <= state_next;
            fetch_pc    <= fetch_pc_next;
            track_pc    <= track_pc_next;
            outstanding <= outstanding_next;
            drop        <= drop_next;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_fetched <= '0;
            perf_dropped <= '0;
            perf_stall   <= '0;
        end else begin
            if (push)                           perf_fetched <= perf_fetched + 32'd1;
            if (imem.rsp_valid && stale)        perf_dropped <= perf_dropped + 32'd1;
            if (instr_valid && !instr_ready)    perf_stall   <= perf_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mips_fetch_queue.sv
// Scoreboard bench for mips_fetch_queue: a latency-programmable imem model checks request
// addresses, a monitor checks every popped instruction against hand-computed expectations.
module tb_mips_fetch_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_out;
    logic [31:0] instr_pc4;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_dropped;
    logic [31:0] perf_stall;
`endif

    mips_fetch_queue_if imem_bus ();

    mips_fetch_queue #(
        .DEPTH    (4),
        .MAX_OUT  (2),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .imem         (imem_bus),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr_out    (instr_out),
        .instr_pc4    (instr_pc4)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched (perf_fetched),
        .perf_dropped (perf_dropped),
        .perf_stall   (perf_stall)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    pend_t       pend[$];
    logic [31:0] exp_addr[$];
    logic [63:0] exp_word[$];
    int          pop_cyc[$];
    int          checks  = 0;
    int          errors  = 0;
    int          budget  = 0;
    int          lat     = 1;
    int          accepts = 0;
    int          mem_cyc = 0;
    int          mon_cyc = 0;

    function automatic logic [31:0] instr_of(input logic [31:0] addr);
        return addr ^ 32'h8C00_5A5A;
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    task automatic report_fail(input string name, input string why);
        checks++;
        errors++;
        $display("[TB] FAIL %s actual=%s expected=none", name, why);
    endtask

    task automatic expect_addrs(input logic [31:0] start, input int n);
        for (int i = 0; i < n; i++) exp_addr.push_back(start + 32'(4 * i));
    endtask

    task automatic expect_words(input logic [31:0] start, input int n);
        for (int i = 0; i < n; i++) begin
            logic [31:0] a;
            a = start + 32'(4 * i);
            exp_word.push_back({instr_of(a), a + 32'd4});
        end
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (!instr_valid && n < 50) begin
            sample();
            n++;
        end
        if (!instr_valid) report_fail(name, "timeout");
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((exp_addr.size() != 0 || exp_word.size() != 0) && n < 300) begin
            sample();
            n++;
        end
        if (exp_addr.size() != 0 || exp_word.size() != 0) report_fail({name, "_drain"}, "timeout");
        repeat (3) sample();
        check_output({name, "_idle"}, 32'(instr_valid), 32'd0);
    endtask

    // Memory model: decides ready/response on the falling edge for the next rising edge.
    always @(negedge clk) begin
        if (!rst) begin
            pend.delete();
            imem_bus.rsp_valid = 1'b0;
            imem_bus.rsp_data  = '0;
            imem_bus.req_ready = 1'b0;
        end else begin
            imem_bus.rsp_valid = 1'b0;
            if (pend.size() > 0 && pend[0].due <= mem_cyc) begin
                imem_bus.rsp_valid = 1'b1;
                imem_bus.rsp_data  = instr_of(pend[0].addr);
                void'(pend.pop_front());
            end
            imem_bus.req_ready = (budget > 0);
            if (imem_bus.req_valid && imem_bus.req_ready) begin
                budget--;
                accepts++;
                if (exp_addr.size() == 0) report_fail("unexpected_req", "extra_request");
                else check_output("req_addr", imem_bus.req_addr, exp_addr.pop_front());
                pend.push_back('{addr: imem_bus.req_addr, due: mem_cyc + lat});
            end
        end
        mem_cyc++;
    end

    // Instruction monitor: every IF/ID handshake consumes one scoreboard entry.
    always @(negedge clk) begin : monitor
        logic [63:0] e;
        mon_cyc++;
        if (rst && instr_valid && instr_ready) begin
            pop_cyc.push_back(mon_cyc);
            if (exp_word.size() == 0) begin
                report_fail("unexpected_pop", "extra_word");
            end else begin
                e = exp_word.pop_front();
                check_output("instr_out", instr_out, e[63:32]);
                check_output("instr_pc4", instr_pc4, e[31:0]);
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base;
        bit found;

        rst         = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        instr_ready = 1'b1;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check_output("rst_req_valid", 32'(imem_bus.req_valid), 32'd0);
        check_output("rst_req_addr", imem_bus.req_addr, 32'd0);
        check_output("rst_instr_valid", 32'(instr_valid), 32'd0);
        check_output("rst_instr_out", instr_out, 32'd0);
        check_output("rst_instr_pc4", instr_pc4, 32'd0);
        rst = 1'b1;
        sample();
        check_output("boot_no_req", 32'(imem_bus.req_valid), 32'd0);

        // Test 1: streaming with one-cycle memory
        step();
        pop_cyc.delete();
        lat    = 1;
        budget = 8;
        expect_addrs(32'h0, 8);
        expect_words(32'h0, 8);
        wait_drain("t1");
        check_output("t1_pops", 32'(pop_cyc.size()), 32'd8);
        if (pop_cyc.size() == 8)
            check_output("t1_no_gap", 32'(pop_cyc[7] - pop_cyc[0]), 32'd7);

        // Test 2: decode stall fills the queue, then release
        step();
        instr_ready = 1'b0;
        budget      = 6;
        expect_addrs(32'd32, 6);
        expect_words(32'd32, 6);
        base = accepts;
        wait_valid("t2_first");
        for (int i = 0; i < 10; i++) begin
            check_output("t2_head_out", instr_out, instr_of(32'd32));
            check_output("t2_head_pc4", instr_pc4, 32'd36);
            step();
        end
        check_output("t2_credit_block", 32'(imem_bus.req_valid), 32'd0);
        check_output("t2_buffered", 32'(accepts - base), 32'd4);
`ifdef FETCH_PERF_CNT_EN
        check_output("t2_perf_stall", perf_stall, 32'd10);
`endif
        instr_ready = 1'b1;
        wait_drain("t2");

        // Test 3: redirect with two requests in flight
        step();
        lat    = 4;
        budget = 2;
        expect_addrs(32'd56, 2);
        base = accepts;
        for (int i = 0; i < 50 && accepts < base + 2; i++) sample();
        if (accepts < base + 2) report_fail("t3_outstanding", "timeout");
        step();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0100;
        lat         = 1;
        budget      = 2;
        expect_addrs(32'h100, 2);
        expect_words(32'h100, 2);
        sample();
        check_output("t3_redir_noreq", 32'(imem_bus.req_valid), 32'd0);
        step();
        redirect = 1'b0;
        sample();
        check_output("t3_drain_hold", 32'(imem_bus.req_valid), 32'd0);
        check_output("t3_bubble", 32'(instr_valid), 32'd0);
        wait_drain("t3");
`ifdef FETCH_PERF_CNT_EN
        check_output("t3_perf_dropped", perf_dropped, 32'd2);
`endif

        // Test 4: redirect together with a pop and a returning response
        step();
        budget = 3;
        expect_addrs(32'h108, 3);
        expect_words(32'h108, 2);
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            sample();
            if (instr_valid && instr_pc4 == 32'h10C) found = 1'b1;
        end
        if (!found) report_fail("t4_sync", "timeout");
        step();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0200;
        budget      = 2;
        expect_addrs(32'h200, 2);
        expect_words(32'h200, 2);
        sample();
        check_output("t4_head_pc4", instr_pc4, 32'h110);
        check_output("t4_rsp_valid", 32'(imem_bus.rsp_valid), 32'd1);
        check_output("t4_redir_noreq", 32'(imem_bus.req_valid), 32'd0);
        step();
        redirect = 1'b0;
        sample();
        check_output("t4_empty", 32'(instr_valid), 32'd0);
        wait_drain("t4");
`ifdef FETCH_PERF_CNT_EN
        check_output("t4_perf_dropped", perf_dropped, 32'd3);
`endif

        // Test 5: asynchronous reset mid-burst
        step();
        instr_ready = 1'b0;
        lat         = 3;
        budget      = 4;
        expect_addrs(32'h208, 4);
        wait_valid("t5_fill");
        #1;
        rst    = 1'b0;
        budget = 0;
        exp_addr.delete();
        exp_word.delete();
        #1;
        check_output("t5_req_valid", 32'(imem_bus.req_valid), 32'd0);
        check_output("t5_req_addr", imem_bus.req_addr, 32'd0);
        check_output("t5_instr_valid", 32'(instr_valid), 32'd0);
        check_output("t5_instr_out", instr_out, 32'd0);
        check_output("t5_instr_pc4", instr_pc4, 32'd0);
`ifdef FETCH_PERF_CNT_EN
        check_output("t5_perf_fetched", perf_fetched, 32'd0);
        check_output("t5_perf_dropped", perf_dropped, 32'd0);
        check_output("t5_perf_stall", perf_stall, 32'd0);
`endif
        step();
        step();
        rst         = 1'b1;
        instr_ready = 1'b1;
        lat         = 1;
        budget      = 2;
        expect_addrs(32'h0, 2);
        expect_words(32'h0, 2);
        wait_drain("t5");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
